i2c_cfg_seq: RTL and testbench

- Parametrised I2C register-configuration sequencer.
- Walks a table of N_ENTRIES 16-bit words ({sub_addr[15:8], data[7:0]}) and issues one 24-bit write per entry, {DEV_ADDR, word}, through the team's existing I2C byte-transaction engine using its GO/END/ACK handshake.
- Adds per-entry retry with a limit, an inter-write gap, restart on demand and status/error reporting.
- Sits between top-level reset/control and the I2C engine, for codec and video-decoder bring-up.

---
 rtl/i2c_cfg_pkg.sv | 11 +
 rtl/i2c_cfg_seq_if.sv | 11 +
 rtl/i2c_tick_div.sv | 23 ++
 rtl/i2c_cfg_seq.sv | 129 ++++++++++++
 tb/tb_i2c_cfg_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared types and table-entry field layout for the I2C configuration sequencer.
package i2c_cfg_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, NEXT, GAP, DONE, FAIL} state_t;

  localparam int SUB_MSB = 15;
  localparam int SUB_LSB = 8;
  localparam int DAT_MSB = 7;
  localparam int DAT_LSB = 0;

  localparam logic [7:0] DELAY_SUB = 8'hFF;
endpackage

// File: rtl/i2c_cfg_seq_if.sv
// Handshake between the configuration sequencer (master) and the I2C byte engine (slave).
interface i2c_cfg_seq_if;
  logic        oTICK;
  logic [23:0] oI2C_DATA;
  logic        oI2C_GO;
  logic        iI2C_END;
  logic        iI2C_ACK;

  modport master (output oTICK, oI2C_DATA, oI2C_GO, input  iI2C_END, iI2C_ACK);
  modport slave  (input  oTICK, oI2C_DATA, oI2C_GO, output iI2C_END, iI2C_ACK);
endinterface

// File: rtl/i2c_tick_div.sv
// Free-running divider: oTICK is a one-cycle pulse every DIV clocks (DIV >= 2).
module i2c_tick_div #(
  parameter int DIV = 2
) (
  input  logic iCLK,
  input  logic iRST_N,
  output logic oTICK
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  // Tick is registered one count early so it lines up with cnt == DIV-1.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt   <= '0;
      oTICK <= 1'b0;
    end else begin
      cnt   <= (cnt == CW'(DIV-1)) ? '0 : cnt + CW'(1);
      oTICK <= (cnt == CW'(DIV-2));
    end
  end
endmodule

// File: rtl/i2c_cfg_seq.sv
// I2C register-configuration sequencer: walks iLUT, one {DEV_ADDR, entry} write per entry with retry.
// Build option I2C_CFG_DELAY_EN: entries with sub_addr 8'hFF become data*256-tick delays.
module i2c_cfg_seq
  import i2c_cfg_pkg::*;
#(
  parameter int         CLK_FREQ  = 50000000,
  parameter int         I2C_FREQ  = 20000,
  parameter int         N_ENTRIES = 11,
  parameter logic [7:0] DEV_ADDR  = 8'h34,
  parameter int         MAX_RETRY = 3,
  parameter int         GAP_TICKS = 2,
  localparam int        IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
  localparam int        RTY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic                   iSTART,
  input  logic [16*N_ENTRIES-1:0] iLUT,
  i2c_cfg_seq_if.master          bus,
  output logic                   oBUSY,
  output logic                   oDONE,
  output logic                   oERR,
  output logic [IDX_W-1:0]       oIDX,
  output logic [RTY_W-1:0]       oRETRY
);
  localparam int TICK_DIV = CLK_FREQ / I2C_FREQ;

  state_t      st;
  logic        pend;
  logic [7:0]  gapCnt;
  logic [15:0] dlyCnt;
  logic [15:0] entry;
  logic        isDly;

  i2c_tick_div #(.DIV(TICK_DIV)) uDiv (.iCLK(iCLK), .iRST_N(iRST_N), .oTICK(bus.oTICK));

  assign entry = iLUT[16*int'(oIDX) +: 16];

`ifdef I2C_CFG_DELAY_EN
  assign isDly = (entry[SUB_MSB:SUB_LSB] == DELAY_SUB);
`else
  assign isDly = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      st            <= IDLE;
      pend          <= 1'b0;
      gapCnt        <= '0;
      dlyCnt        <= '0;
      bus.oI2C_DATA <= '0;
      bus.oI2C_GO   <= 1'b0;
      oBUSY         <= 1'b0;
      oDONE         <= 1'b0;
      oERR          <= 1'b0;
      oIDX          <= '0;
      oRETRY        <= '0;
    end else begin
      // Restart requests only survive while idle; anything seen mid-sequence is dropped.
      pend <= (pend | iSTART) & ~oBUSY;
      if (bus.oTICK) begin
        unique case (st)
          IDLE: begin
            pend  <= 1'b0;
            oBUSY <= 1'b1;
            oIDX  <= '0;
            st    <= LOAD;
          end
          LOAD: begin
            if (isDly) begin
              dlyCnt <= {entry[DAT_MSB:DAT_LSB], 8'h00};
              st     <= (entry[DAT_MSB:DAT_LSB] == 8'h00) ? NEXT : WAIT;
            end else begin
              bus.oI2C_DATA <= {DEV_ADDR, entry};
              bus.oI2C_GO   <= 1'b1;
              st            <= WAIT;
            end
          end
          WAIT: begin
            if (isDly) begin
              dlyCnt <= dlyCnt - 16'd1;
              if (dlyCnt == 16'd1) st <= NEXT;
            end else if (bus.iI2C_END) begin
              bus.oI2C_GO <= 1'b0;
              if (!bus.iI2C_ACK) begin
                st <= NEXT;
              end else if (oRETRY < RTY_W'(MAX_RETRY)) begin
                oRETRY <= oRETRY + RTY_W'(1);
                st     <= LOAD;
              end else begin
                oERR  <= 1'b1;
                oBUSY <= 1'b0;
                st    <= FAIL;
              end
            end
          end
          NEXT: begin
            oRETRY <= '0;
            if (oIDX == IDX_W'(N_ENTRIES-1)) begin
              oDONE <= 1'b1;
              oBUSY <= 1'b0;
              st    <= DONE;
            end else begin
              oIDX   <= oIDX + IDX_W'(1);
              gapCnt <= 8'(GAP_TICKS);
              st     <= (GAP_TICKS == 0) ? LOAD : GAP;
            end
          end
          GAP: begin
            gapCnt <= gapCnt - 8'd1;
            if (gapCnt <= 8'd1) st <= LOAD;
          end
          DONE, FAIL: begin
            if (pend) begin
              pend   <= 1'b0;
              oDONE  <= 1'b0;
              oERR   <= 1'b0;
              oRETRY <= '0;
              oIDX   <= '0;
              oBUSY  <= 1'b1;
              st     <= LOAD;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Scoreboard bench for i2c_cfg_seq: expected writes queued by stimulus, checked on each GO rise.
module tb_i2c_cfg_seq;
  typedef struct packed {
    logic [23:0] data;
    logic [1:0]  rty;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic [47:0] lut = {16'h1201, 16'h0C00, 16'h001A};
  logic        busy, done, err;
  logic [1:0]  idx, rty;

  i2c_cfg_seq_if bus ();

  i2c_cfg_seq #(
    .CLK_FREQ(8), .I2C_FREQ(1), .N_ENTRIES(3), .DEV_ADDR(8'h34),
    .MAX_RETRY(2), .GAP_TICKS(2)
  ) dut (
    .iCLK(clk), .iRST_N(rstN), .iSTART(start), .iLUT(lut), .bus(bus),
    .oBUSY(busy), .oDONE(done), .oERR(err), .oIDX(idx), .oRETRY(rty)
  );

  always #5 clk = ~clk;

  exp_t expQ[$];
  logic ackQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic pushExp(logic [23:0] d, logic [1:0] r);
    expQ.push_back(exp_t'({d, r}));
  endtask

  // Engine model: END (with queued ACK value) four ticks after GO, held until GO drops.
  int eCnt;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bus.iI2C_END <= 1'b0;
      bus.iI2C_ACK <= 1'b0;
      eCnt         <= 0;
    end else if (bus.oTICK) begin
      if (!bus.oI2C_GO) begin
        bus.iI2C_END <= 1'b0;
        eCnt         <= 0;
      end else if (!bus.iI2C_END) begin
        if (eCnt == 3) begin
          bus.iI2C_END <= 1'b1;
          bus.iI2C_ACK <= (ackQ.size() > 0) ? ackQ.pop_front() : 1'b0;
        end
        eCnt <= eCnt + 1;
      end
    end
  end

  logic goPrev = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (bus.oI2C_GO && !goPrev) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_go data=%h expected no write", bus.oI2C_DATA);
      end else begin
        e = expQ.pop_front();
        chk("go_data", 32'(bus.oI2C_DATA), 32'(e.data));
        chk("go_retry", 32'(rty), 32'(e.rty));
      end
    end
    goPrev = bus.oI2C_GO;
  end

  function automatic logic sig(int w);
    case (w)
      0:       return done;
      1:       return err;
      2:       return bus.oI2C_GO;
      3:       return busy;
      default: return bus.oTICK;
    endcase
  endfunction

  task automatic waitSig(string nm, int w, int budget);
    int n = 0;
    while (!sig(w) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!sig(w)) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s still low after %0d cycles", nm, budget);
    end
  endtask

  task automatic pulseStart();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic chkResetState(string tag);
    chk({tag, "_tick"},  32'(bus.oTICK), 0);
    chk({tag, "_data"},  32'(bus.oI2C_DATA), 0);
    chk({tag, "_go"},    32'(bus.oI2C_GO), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_err"},   32'(err), 0);
    chk({tag, "_idx"},   32'(idx), 0);
    chk({tag, "_retry"}, 32'(rty), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chkResetState("reset");

    // Run 1: all ACK; a start pulse mid-transfer must be ignored.
    pushExp(24'h34001A, 2'd0);
    pushExp(24'h340C00, 2'd0);
    pushExp(24'h341201, 2'd0);
    rstN = 1'b1;
    waitSig("tick1", 4, 40);
    @(negedge clk);
    n = 1;
    while (!bus.oTICK && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tick_period", 32'(n), 8);
    waitSig("go_e0", 2, 200);
    pulseStart();
    waitSig("done1", 0, 1500);
    chk("run1_done", 32'(done), 1);
    chk("run1_busy", 32'(busy), 0);
    chk("run1_err", 32'(err), 0);
    chk("run1_idx", 32'(idx), 2);
    chk("run1_pending", 32'(expQ.size()), 0);
    repeat (48) @(negedge clk);
    chk("run1_done_hold", 32'(done), 1);

    // Run 2: restart after DONE, entry 1 NACKed once.
    ackQ = '{1'b0, 1'b1, 1'b0, 1'b0};
    pushExp(24'h34001A, 2'd0);
    pushExp(24'h340C00, 2'd0);
    pushExp(24'h340C00, 2'd1);
    pushExp(24'h341201, 2'd0);
    pulseStart();
    waitSig("busy2", 3, 30);
    chk("run2_done_cleared", 32'(done), 0);
    waitSig("done2", 0, 2000);
    chk("run2_done", 32'(done), 1);
    chk("run2_err", 32'(err), 0);
    chk("run2_idx", 32'(idx), 2);
    chk("run2_retry", 32'(rty), 0);
    chk("run2_pending", 32'(expQ.size()), 0);

    // Run 3: entry 2 always NACKed -> three attempts then FAIL.
    ackQ = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    pushExp(24'h34001A, 2'd0);
    pushExp(24'h340C00, 2'd0);
    pushExp(24'h341201, 2'd0);
    pushExp(24'h341201, 2'd1);
    pushExp(24'h341201, 2'd2);
    pulseStart();
    waitSig("err3", 1, 3000);
    chk("run3_err", 32'(err), 1);
    chk("run3_idx", 32'(idx), 2);
    chk("run3_retry", 32'(rty), 2);
    chk("run3_done", 32'(done), 0);
    chk("run3_go", 32'(bus.oI2C_GO), 0);
    chk("run3_busy", 32'(busy), 0);
    chk("run3_pending", 32'(expQ.size()), 0);

    // Run 4: reset while GO is high, then a clean sequence from entry 0.
    ackQ.delete();
    pushExp(24'h34001A, 2'd0);
    pulseStart();
    waitSig("go4", 2, 200);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    chkResetState("midreset");
    pushExp(24'h34001A, 2'd0);
    pushExp(24'h340C00, 2'd0);
    pushExp(24'h341201, 2'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    waitSig("done4", 0, 1500);
    chk("run4_done", 32'(done), 1);
    chk("run4_err", 32'(err), 0);
    chk("run4_idx", 32'(idx), 2);
    chk("run4_pending", 32'(expQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
